// File: rtl/pending_flag_arbiter_pkg.sv
// pending_flag_arbiter_pkg: shared types for the pending-flag arbiter
package pending_flag_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/pending_flag_arbiter_rr_priority_select.sv
// rr_priority_select: round-robin find-first from a start pointer, wrapping high to low
module rr_priority_select #(
    parameter int WIDTH = 16,
    parameter int ID_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    logic [WIDTH-1:0] rot;
    logic [ID_W-1:0]  off;
    logic [ID_W:0]    sum;

    // rotate the doubled request so ptr lands at bit 0, take the lowest set bit, then map back
    always_comb begin
        rot   = WIDTH'({req, req} >> ptr);
        off   = '0;
        found = |req;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (rot[i]) off = ID_W'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= (ID_W + 1)'(WIDTH)) ? ID_W'(sum - (ID_W + 1)'(WIDTH)) : sum[ID_W-1:0];
    end

endmodule

// File: rtl/pending_flag_arbiter.sv
// pending_flag_arbiter: holds set pulses as pending flags and issues them one at a time round-robin
module pending_flag_arbiter
    import pending_flag_arbiter_pkg::*;
#(
    parameter int              WIDTH       = 16,
    parameter logic [WIDTH-1:0] RST_PENDING = '0,
    localparam int             ID_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] set,
    input  logic             flush,
    output logic [WIDTH-1:0] pending,
    output logic             out_valid,
    output logic [ID_W-1:0]  out_id,
    input  logic             out_ack
);

    state_t           state, state_next;
    logic [ID_W-1:0]  rr_ptr, ptr_next, id_next, sel;
    logic [WIDTH-1:0] pending_next, issue_clr;
    logic             found;

    rr_priority_select #(.WIDTH(WIDTH), .ID_W(ID_W)) u_sel (
        .req   (pending),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (sel)
    );

    assign out_valid = (state == HOLD);

    // state, issued id, round-robin pointer and pending flags; reset wins over everything
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            out_id  <= '0;
            rr_ptr  <= '0;
            pending <= RST_PENDING;
        end else begin
            state   <= state_next;
            out_id  <= id_next;
            rr_ptr  <= ptr_next;
            pending <= pending_next;
        end
    end

    // issue when the slot is open and something is pending; flush overrides set and issue
    always_comb begin
        state_next   = state;
        id_next      = out_id;
        ptr_next     = rr_ptr;
        issue_clr    = '0;
        pending_next = '0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            if (state == IDLE || out_ack) begin
                if (found) begin
                    state_next = HOLD;
                    id_next    = sel;
                    issue_clr  = WIDTH'(1) << sel;
                    ptr_next   = (sel == ID_W'(WIDTH - 1)) ? '0 : sel + 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            pending_next = set | (pending & ~issue_clr);
        end
    end

endmodule

// File: tb/tb_pending_flag_arbiter.sv
// tb_pending_flag_arbiter: directed self-checking bench for pending_flag_arbiter
module tb_pending_flag_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] set;
    logic        flush;
    logic [15:0] pending;
    logic        out_valid;
    logic [3:0]  out_id;
    logic        out_ack;

    int tests  = 0;
    int failed = 0;

    pending_flag_arbiter #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .set       (set),
        .flush     (flush),
        .pending   (pending),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_ack   (out_ack)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] id, input logic [15:0] p);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".id"}, 32'(out_id), 32'(id));
        chk({tag, ".pending"}, 32'(pending), 32'(p));
    endtask

    task automatic chk_ptr(input string tag, input logic [3:0] p);
        chk({tag, ".rr_ptr"}, 32'(dut.rr_ptr), 32'(p));
    endtask

    initial begin
        rst = 1'b0; set = '0; flush = 1'b0; out_ack = 1'b0;
        step();
        chk_out("reset", 1'b0, 4'd0, 16'h0000);
        chk_ptr("reset", 4'd0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_out("idle", 1'b0, 4'd0, 16'h0000);
        end

        // two bits, continuous ack
        set = 16'h0021; out_ack = 1'b1;
        step();
        chk_out("rr.set", 1'b0, 4'd0, 16'h0021);
        set = '0;
        step();
        chk_out("rr.first", 1'b1, 4'd0, 16'h0020);
        step();
        chk_out("rr.second", 1'b1, 4'd5, 16'h0000);
        chk_ptr("rr.second", 4'd6);
        step();
        chk_out("rr.drain", 1'b0, 4'd5, 16'h0000);

        // stall with ack low
        set = 16'h0300; out_ack = 1'b0;
        step();
        chk_out("stall.set", 1'b0, 4'd5, 16'h0300);
        set = '0;
        step();
        chk_out("stall.issue", 1'b1, 4'd8, 16'h0200);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("stall.hold", 1'b1, 4'd8, 16'h0200);
        end
        chk_ptr("stall.hold", 4'd9);
        out_ack = 1'b1;
        step();
        chk_out("stall.next", 1'b1, 4'd9, 16'h0000);
        step();
        chk_out("stall.done", 1'b0, 4'd9, 16'h0000);
        out_ack = 1'b0;

        // wrap-around from pointer 15
        set = 16'h4000;
        step();
        set = '0;
        step();
        chk_out("wrap.14", 1'b1, 4'd14, 16'h0000);
        chk_ptr("wrap.14", 4'd15);
        set = 16'h8004;
        step();
        chk_out("wrap.set", 1'b1, 4'd14, 16'h8004);
        set = '0; out_ack = 1'b1;
        step();
        chk_out("wrap.15", 1'b1, 4'd15, 16'h0004);
        chk_ptr("wrap.15", 4'd0);
        step();
        chk_out("wrap.2", 1'b1, 4'd2, 16'h0000);
        chk_ptr("wrap.2", 4'd3);
        step();
        chk_out("wrap.done", 1'b0, 4'd2, 16'h0000);
        out_ack = 1'b0;

        // set on the bit being issued stays pending and re-issues
        set = 16'h0008;
        step();
        chk_out("sim.set", 1'b0, 4'd2, 16'h0008);
        step();
        chk_out("sim.issue", 1'b1, 4'd3, 16'h0008);
        chk_ptr("sim.issue", 4'd4);
        set = '0; out_ack = 1'b1;
        step();
        chk_out("sim.reissue", 1'b1, 4'd3, 16'h0000);
        step();
        chk_out("sim.done", 1'b0, 4'd3, 16'h0000);
        out_ack = 1'b0;

        // flush beats set and issue
        set = 16'h0001;
        step();
        set = '0;
        step();
        chk_out("flush.pre", 1'b1, 4'd0, 16'h0000);
        chk_ptr("flush.pre", 4'd1);
        flush = 1'b1; set = 16'hFFFF; out_ack = 1'b1;
        step();
        chk_out("flush", 1'b0, 4'd0, 16'h0000);
        chk_ptr("flush", 4'd1);
        flush = 1'b0; set = '0;
        step();
        chk_out("flush.after", 1'b0, 4'd0, 16'h0000);
        out_ack = 1'b0;

        // reset in the middle of a handshake
        set = 16'h0010;
        step();
        set = 16'h0002;
        step();
        chk_out("rst.hold", 1'b1, 4'd4, 16'h0002);
        chk_ptr("rst.hold", 4'd5);
        set = 16'h0040; rst = 1'b0;
        step();
        chk_out("rst.mid", 1'b0, 4'd0, 16'h0000);
        chk_ptr("rst.mid", 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
